// File: rtl/sonar_bus_pkg.sv
// Shared definitions for the sonar register bus: register map bounds, data width
// and the initiator state encoding.
package sonar_bus_pkg;

    localparam int BUS_WIDTH = 16;

    // Register map spans CONTROL (first) through FB1 (last).
    localparam logic [3:0] CONTROL_ADDR = 4'd0;
    localparam logic [3:0] FB1_ADDR     = 4'd12;
    localparam int         NUM_REGS     = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } bus_state_e;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Access watchdog: counts cycles spent waiting for ack and flags the last allowed one.
module bus_timeout_cnt #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 8'd1;
    end

    assign expire = (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/sonar_bus_master.sv
// Initiator for the sonar register bus: one read/write access per command, one
// response per command, with select checking and an ack timeout.
module sonar_bus_master #(
    parameter int N_SLAVES  = 4,
    parameter int SEL_W     = 2,
    parameter int BUS_WIDTH = sonar_bus_pkg::BUS_WIDTH,
    parameter int TIMEOUT   = 15
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [SEL_W-1:0]     cmd_sel_i,
    input  logic [3:0]           cmd_adr_i,
    input  logic [BUS_WIDTH-1:0] cmd_dat_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [BUS_WIDTH-1:0] rsp_dat_o,
    output logic                 rsp_err_o,
    output logic [N_SLAVES-1:0]  m_valid_o,
    output logic [3:0]           m_adr_o,
    output logic [BUS_WIDTH-1:0] m_dat_o,
    output logic                 m_strb_o,
    input  logic                 m_ack_i,
    input  logic [BUS_WIDTH-1:0] m_dat_i,
    output logic                 busy_o
);

    import sonar_bus_pkg::*;

    bus_state_e          state;
    logic [N_SLAVES-1:0] sel_onehot;
    logic                accept;
    logic                expire;

    // An out-of-range select decodes to all zeros, which doubles as the error test.
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < N_SLAVES; i++)
            sel_onehot[i] = (int'(cmd_sel_i) == i);
    end

    assign cmd_ready_o = (state == IDLE) & ~wb_rst_i;
    assign accept      = cmd_valid_i & cmd_ready_o;

    bus_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clr    (accept),
        .en     (state == REQ),
        .expire (expire)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            m_valid_o   <= '0;
            m_adr_o     <= '0;
            m_dat_o     <= '0;
            m_strb_o    <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        busy_o <= 1'b1;
                        if (|sel_onehot) begin
                            state     <= REQ;
                            m_valid_o <= sel_onehot;
                            m_adr_o   <= cmd_adr_i;
                            m_dat_o   <= cmd_dat_i;
                            m_strb_o  <= cmd_we_i;
                        end else begin
                            state       <= RSP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_dat_o   <= '0;
                        end
                    end
                end
                REQ: begin
                    // Ack is checked first so a late ack on the expiry edge still succeeds.
                    if (m_ack_i) begin
                        state       <= RSP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b0;
                        rsp_dat_o   <= m_dat_i;
                        m_valid_o   <= '0;
                        m_strb_o    <= 1'b0;
                    end else if (expire) begin
                        state       <= RSP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_dat_o   <= '0;
                        m_valid_o   <= '0;
                        m_strb_o    <= 1'b0;
                    end
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sonar_bus_master.sv
// Directed + randomized bench for sonar_bus_master with three register-file slaves
// and a transaction-level model of expected responses.
module tb_sonar_bus_master;

    import sonar_bus_pkg::*;

    localparam int NS = 3;
    localparam int SW = 2;
    localparam int BW = 16;
    localparam int TO = 15;

    logic          clk, rst;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [SW-1:0] cmd_sel;
    logic [3:0]    cmd_adr;
    logic [BW-1:0] cmd_dat;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [BW-1:0] rsp_dat;
    logic [NS-1:0] m_valid;
    logic [3:0]    m_adr;
    logic [BW-1:0] m_dat, m_rdat;
    logic          m_strb, m_ack, busy;

    logic          mute, force_ack;
    logic [BW-1:0] force_dat;
    logic [NS-1:0] slv_ack;
    logic [BW-1:0] slv_rd   [NS];
    logic [BW-1:0] slv_regs [NS][16];
    logic [BW-1:0] mdl      [NS][16];

    int n_chk  = 0;
    int n_fail = 0;

    sonar_bus_master #(
        .N_SLAVES (NS),
        .SEL_W    (SW),
        .BUS_WIDTH(BW),
        .TIMEOUT  (TO)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_we_i   (cmd_we),
        .cmd_sel_i  (cmd_sel),
        .cmd_adr_i  (cmd_adr),
        .cmd_dat_i  (cmd_dat),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_dat_o  (rsp_dat),
        .rsp_err_o  (rsp_err),
        .m_valid_o  (m_valid),
        .m_adr_o    (m_adr),
        .m_dat_o    (m_dat),
        .m_strb_o   (m_strb),
        .m_ack_i    (m_ack),
        .m_dat_i    (m_rdat),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave with registered ack (one pulse per access) and registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slv_ack <= '0;
            for (int s = 0; s < NS; s++) begin
                slv_rd[s] <= '0;
                for (int a = 0; a < 16; a++) slv_regs[s][a] <= '0;
            end
        end else begin
            for (int s = 0; s < NS; s++) begin
                if (m_valid[s] && m_strb) slv_regs[s][m_adr] <= m_dat;
                slv_ack[s] <= m_valid[s] & ~slv_ack[s] & ~mute;
                slv_rd[s]  <= slv_regs[s][m_adr];
            end
        end
    end

    always_comb begin
        m_rdat = '0;
        for (int s = 0; s < NS; s++)
            if (slv_ack[s]) m_rdat = m_rdat | slv_rd[s];
        if (force_ack) m_rdat = force_dat;
    end
    assign m_ack = force_ack | (|slv_ack);

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept_cmd(input logic we, input logic [1:0] sel, input logic [3:0] adr,
                              input logic [15:0] dat);
        int g = 0;
        cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat; cmd_valid = 1'b1;
        while (!cmd_ready && g < 50) begin
            @(posedge clk); #1; g++;
        end
        check("cmd_accept", 32'(g < 50), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic we, input logic [1:0] sel, input logic [3:0] adr,
                           input logic [15:0] dat, output logic [15:0] rd, output logic er,
                           output int lat, output int vcnt, output logic oh_ok);
        logic [NS-1:0] exp_oh;
        exp_oh = (int'(sel) < NS) ? NS'(1 << sel) : '0;
        accept_cmd(we, sel, adr, dat);
        lat = 0; vcnt = 0; oh_ok = 1'b1;
        while (!rsp_valid && lat < 40) begin
            if (m_valid != '0) vcnt++;
            if (m_valid != '0 && m_valid != exp_oh) oh_ok = 1'b0;
            @(posedge clk); #1; lat++;
        end
        if (m_valid != '0) oh_ok = 1'b0;
        rd = rsp_dat;
        er = rsp_err;
    endtask

    // Runs one command and checks it against the register-file model.
    task automatic txn(input logic we, input logic [1:0] sel, input logic [3:0] adr,
                       input logic [15:0] dat, output logic [15:0] rd);
        logic er, oh;
        int lat, vcnt, span;
        logic [15:0] exp_d;
        logic exp_e;
        int exp_lat, exp_span;
        run_cmd(we, sel, adr, dat, rd, er, lat, vcnt, oh);
        if (int'(sel) < NS) begin
            exp_d = mdl[sel][adr];
            if (we) mdl[sel][adr] = dat;
            exp_e = 1'b0; exp_lat = 2; exp_span = 3;
        end else begin
            exp_d = '0; exp_e = 1'b1; exp_lat = 0; exp_span = 0;
        end
        span = (vcnt == 0) ? 0 : vcnt + 1;
        check("rsp_dat", 32'(rd), 32'(exp_d));
        check("rsp_err", 32'(er), 32'(exp_e));
        check("rsp_latency", 32'(lat), 32'(exp_lat));
        check("valid_edge_span", 32'(span), 32'(exp_span));
        check("valid_onehot", 32'(oh), 32'd1);
    endtask

    initial begin
        logic [15:0] rd, d0;
        logic e0, er, oh, stable, rdy0, noacc, pulse;
        int lat, vcnt, n;

        cmd_valid = 0; cmd_we = 0; cmd_sel = '0; cmd_adr = '0; cmd_dat = '0;
        rsp_ready = 1; mute = 0; force_ack = 0; force_dat = '0;
        for (int s = 0; s < NS; s++)
            for (int a = 0; a < 16; a++) mdl[s][a] = '0;

        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_outs", 32'({rsp_valid, rsp_err, rsp_dat, busy}), 32'd0);
        check("rst_bus_outs", 32'({m_valid, m_strb, m_adr, m_dat}), 32'd0);
        rst = 0;
        #1;
        check("ready_after_init", 32'(cmd_ready), 32'd1);

        // Write CONTROL on instance 1, then read it back.
        txn(1'b1, 2'd1, CONTROL_ADDR, 16'h0016, rd);
        txn(1'b0, 2'd1, CONTROL_ADDR, 16'h0000, rd);
        check("readback_control", 32'(rd), 32'h0016);

        // Select beyond the populated instances.
        txn(1'b0, 2'd3, 4'd2, 16'h0000, rd);

        for (int i = 0; i < 30; i++)
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                4'($urandom_range(0, int'(FB1_ADDR))), 16'($urandom), rd);

        // Silent slave: access times out.
        mute = 1;
        accept_cmd(1'b0, 2'd1, 4'd3, 16'h0000);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("timeout_edges", 32'(n), 32'(TO));
        check("timeout_err", 32'(rsp_err), 32'd1);
        check("timeout_dat", 32'(rsp_dat), 32'd0);
        check("timeout_valid_clr", 32'(m_valid), 32'd0);

        // Ack arriving exactly on the expiry edge wins.
        accept_cmd(1'b0, 2'd0, 4'd2, 16'h0000);
        repeat (TO - 1) begin
            @(posedge clk); #1;
        end
        check("ack_last_pre", 32'(rsp_valid), 32'd0);
        force_ack = 1; force_dat = 16'hBEEF;
        @(posedge clk); #1;
        force_ack = 0;
        check("ack_last_valid", 32'(rsp_valid), 32'd1);
        check("ack_last_err", 32'(rsp_err), 32'd0);
        check("ack_last_dat", 32'(rsp_dat), 32'h0000BEEF);
        mute = 0;

        // Backpressure: response held while a second command waits.
        @(posedge clk); #1;
        rsp_ready = 0;
        mdl[2][5] = mdl[2][5];
        run_cmd(1'b0, 2'd2, 4'd5, 16'h0000, d0, e0, lat, vcnt, oh);
        check("bp_first_dat", 32'(d0), 32'(mdl[2][5]));
        check("bp_first_err", 32'(e0), 32'd0);
        cmd_we = 1; cmd_sel = 2'd0; cmd_adr = 4'd1; cmd_dat = 16'h1234; cmd_valid = 1;
        stable = 1; rdy0 = 1; noacc = 1;
        repeat (10) begin
            @(posedge clk); #1;
            if (!(rsp_valid && rsp_dat == d0 && rsp_err == e0)) stable = 0;
            if (cmd_ready) rdy0 = 0;
            if (m_valid != '0) noacc = 0;
        end
        check("bp_rsp_stable", 32'(stable), 32'd1);
        check("bp_cmd_ready_low", 32'(rdy0), 32'd1);
        check("bp_no_second_accept", 32'(noacc), 32'd1);
        rsp_ready = 1;
        @(posedge clk); #1;
        check("bp_handshake", 32'(rsp_valid), 32'd0);
        txn(1'b1, 2'd0, 4'd1, 16'h1234, rd);
        txn(1'b0, 2'd0, 4'd1, 16'h0000, rd);

        // Reset one cycle into an access.
        accept_cmd(1'b0, 2'd2, 4'd0, 16'h0000);
        @(posedge clk); #1;
        rst = 1;
        #1;
        check("midrst_valid", 32'(m_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        for (int s = 0; s < NS; s++)
            for (int a = 0; a < 16; a++) mdl[s][a] = '0;
        @(posedge clk); #1;
        rst = 0;
        #1;
        check("midrst_ready_after", 32'(cmd_ready), 32'd1);
        pulse = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_valid) pulse = 1;
        end
        check("midrst_no_rsp", 32'(pulse), 32'd0);
        txn(1'b0, 2'd1, CONTROL_ADDR, 16'h0000, rd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
